// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
//
// Strips a header of S = byte_strip_cnt+1 bytes (1..DATA_BYTE_WD) from the
// front of each AXI-Stream packet. The remaining payload is realigned to the
// MSB of each beat. The first input beat is reported on the header sideband.
// Byte 0 of a beat is data[DATA_WD-1 -: 8]; keep bit DATA_BYTE_WD-1 is byte 0.
//
// Optional feature: define STRIP_KEEP_CHECK_EN to add the sticky err_keep
// output, which flags illegal keep patterns on accepted input beats.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   valid_in, data_in, keep_in, last_in, ready_in        input stream
//   valid_out, data_out, keep_out, last_out, ready_out   realigned output stream
//   valid_strip, byte_strip_cnt, ready_strip             strip command (S-1)
//   valid_header, data_header, keep_header               captured header (pulse)
//   err_keep        (STRIP_KEEP_CHECK_EN only) sticky keep-legality error
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
`ifdef STRIP_KEEP_CHECK_EN
  ,
  output logic                    err_keep
`endif
);

  // Byte counts range 0..DATA_BYTE_WD, so they need one bit more than the
  // command field.
  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] NB = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [DATA_WD-1:0]   res;
  logic [CW-1:0]        s_len;
  logic [CW-1:0]        l_len;
  logic [CW-1:0]        l_in;
  logic [CW+2:0]        sh_res;
  logic [CW+2:0]        sh_in;
  logic [DATA_WD-1:0]   data_raw;
  logic [DATA_BYTE_WD-1:0] keep_raw;

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  // Mask with the top n keep bits set (n = 0..DATA_BYTE_WD).
  function automatic logic [DATA_BYTE_WD-1:0] top_bits(input logic [CW-1:0] n);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign l_in   = popcount(keep_in);
  // Residual bytes move up by S byte lanes; new-beat bytes move down by N-S.
  // When S = N the residual shifts out entirely and data_in passes unchanged.
  assign sh_res = {s_len, 3'b000};
  assign sh_in  = {(NB - s_len), 3'b000};

  always_comb begin
    state_nxt   = state;
    ready_strip = 1'b0;
    ready_in    = 1'b0;
    valid_out   = 1'b0;
    last_out    = 1'b0;
    data_raw    = '0;
    keep_raw    = '0;
    case (state)
      IDLE: begin
        ready_strip = 1'b1;
        if (valid_strip) state_nxt = FIRST;
      end
      FIRST: begin
        ready_in = 1'b1;
        if (valid_in) begin
          if (!last_in)          state_nxt = BODY;
          else if (l_in > s_len) state_nxt = FLUSH;
          else                   state_nxt = IDLE;
        end
      end
      BODY: begin
        ready_in  = ready_out;
        valid_out = valid_in;
        data_raw  = (res << sh_res) | (data_in >> sh_in);
        keep_raw  = '1;
        if (last_in && (l_in <= s_len)) begin
          last_out = 1'b1;
          keep_raw = top_bits(NB - s_len + l_in);
        end
        if (valid_in && ready_out && last_in)
          state_nxt = (l_in <= s_len) ? IDLE : FLUSH;
      end
      FLUSH: begin
        valid_out = 1'b1;
        last_out  = 1'b1;
        data_raw  = res << sh_res;
        keep_raw  = top_bits(l_len - s_len);
        if (ready_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The command port must read as not-ready while reset is held.
    if (rst) ready_strip = 1'b0;
  end

  assign keep_out = keep_raw;
  assign data_out = data_raw & byte_mask(keep_raw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      res          <= '0;
      s_len        <= '0;
      l_len        <= '0;
      data_header  <= '0;
      keep_header  <= '0;
      valid_header <= 1'b0;
    end else begin
      state        <= state_nxt;
      valid_header <= 1'b0;
      if (state == IDLE && valid_strip)
        s_len <= CW'(byte_strip_cnt) + CW'(1);
      if (state == FIRST && valid_in) begin
        res          <= data_in;
        data_header  <= data_in;
        keep_header  <= top_bits(s_len);
        valid_header <= 1'b1;
        if (last_in) l_len <= l_in;
      end
      if (state == BODY && valid_in && ready_out) begin
        res <= data_in;
        if (last_in) l_len <= l_in;
      end
    end
  end

`ifdef STRIP_KEEP_CHECK_EN
  logic [DATA_BYTE_WD-1:0] keep_inv;
  logic                    keep_bad;

  // A legal keep is ones followed by zeros from the MSB, i.e. its inverse is
  // a contiguous run of low ones (inv & (inv+1) == 0).
  assign keep_inv = ~keep_in;
  assign keep_bad = (keep_in == '0) ||
                    ((keep_inv & (keep_inv + DATA_BYTE_WD'(1))) != '0) ||
                    (!last_in && (keep_in != '1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_keep <= 1'b0;
    else if (valid_in && ready_in && keep_bad) err_keep <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header (32-bit data, 4 bytes per beat).
module tb_axi_stream_strip_header;

  localparam int DATA_WD = 32;
  localparam int NB      = 4;
  localparam int CW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_WD-1:0] data_in;
  logic [NB-1:0]     keep_in;
  logic              last_in;
  logic              ready_in;
  logic              valid_out;
  logic [DATA_WD-1:0] data_out;
  logic [NB-1:0]     keep_out;
  logic              last_out;
  logic              ready_out;
  logic              valid_strip;
  logic [CW-1:0]     byte_strip_cnt;
  logic              ready_strip;
  logic              valid_header;
  logic [DATA_WD-1:0] data_header;
  logic [NB-1:0]     keep_header;
`ifdef STRIP_KEEP_CHECK_EN
  logic              err_keep;
`endif

  int checks = 0;
  int errors = 0;

  axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out),
    .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header)
`ifdef STRIP_KEEP_CHECK_EN
    , .err_keep(err_keep)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: record transferred output beats {last, keep, data}, header
  // pulses, and any change of the output while it is stalled.
  logic [36:0]        outq[$];
  int                 hdr_cnt;
  logic [DATA_WD-1:0] hdr_data;
  logic [NB-1:0]      hdr_keep;
  int                 stall_cnt;
  int                 stall_err;
  logic               prev_stall = 1'b0;
  logic [36:0]        prev_beat;

  always @(negedge clk) begin
    if (prev_stall && (!valid_out || {last_out, keep_out, data_out} != prev_beat))
      stall_err++;
    prev_stall = valid_out && !ready_out && !rst;
    prev_beat  = {last_out, keep_out, data_out};
    if (valid_out && !ready_out) stall_cnt++;
    if (valid_out && ready_out) outq.push_back({last_out, keep_out, data_out});
    if (valid_header) begin
      hdr_cnt++;
      hdr_data = data_header;
      hdr_keep = keep_header;
    end
  end

  task automatic clear_mon();
    outq.delete();
    hdr_cnt   = 0;
    stall_cnt = 0;
    stall_err = 0;
  endtask

  task automatic send_strip(input logic [CW-1:0] cnt);
    bit ok = 0;
    valid_strip    = 1'b1;
    byte_strip_cnt = cnt;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready_strip) ok = 1;
      @(posedge clk); #1;
    end
    valid_strip = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL strip_timeout got no ready_strip, want ready_strip=1");
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready_in) ok = 1;
      @(posedge clk); #1;
    end
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout data %h got no ready_in, want ready_in=1", d);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; data_in = 32'hDEADBEEF; keep_in = 4'hF; last_in = 1'b0;
    ready_out = 1'b1; valid_strip = 1'b1; byte_strip_cnt = 2'd1;
    idle_cycles(2);
    checks++;
    if ({ready_in, ready_strip, valid_out, last_out, valid_header} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b, want 00000",
               {ready_in, ready_strip, valid_out, last_out, valid_header});
    end
    checks++;
    if ({data_header, keep_header, data_out, keep_out} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data got %h, want 0", {data_header, keep_header, data_out, keep_out});
    end
    valid_in = 1'b0; valid_strip = 1'b0; keep_in = '0; data_in = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (ready_strip !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle ready_strip got %b, want 1", ready_strip);
    end
  endtask

  task automatic test_exact_fit(input bit bp);
    string nm = bp ? "bp" : "exact";
    clear_mon();
    if (bp) begin
      ready_out = 1'b0;
      fork
        begin
          send_strip(2'd1);
          send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
          send_beat(32'h11223344, 4'b1111, 1'b0);
          send_beat(32'h55660000, 4'b1100, 1'b1);
        end
        begin
          repeat (40) begin
            @(posedge clk); #1;
            ready_out = ~ready_out;
          end
        end
      join
      ready_out = 1'b1;
    end else begin
      ready_out = 1'b1;
      send_strip(2'd1);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'h11223344, 4'b1111, 1'b0);
      send_beat(32'h55660000, 4'b1100, 1'b1);
    end
    idle_cycles(4);
    checks++;
    if (outq.size() !== 2) begin
      errors++;
      $display("FAIL %s_count got %0d beats, want 2", nm, outq.size());
    end else begin
      checks++;
      if (outq[0] !== {1'b0, 4'b1111, 32'hCCDD1122}) begin
        errors++;
        $display("FAIL %s_beat0 got %h, want %h", nm, outq[0], {1'b0, 4'b1111, 32'hCCDD1122});
      end
      checks++;
      if (outq[1] !== {1'b1, 4'b1111, 32'h33445566}) begin
        errors++;
        $display("FAIL %s_beat1 got %h, want %h", nm, outq[1], {1'b1, 4'b1111, 32'h33445566});
      end
    end
    checks++;
    if (hdr_cnt !== 1 || hdr_data !== 32'hAABBCCDD || hdr_keep !== 4'b1100) begin
      errors++;
      $display("FAIL %s_header got cnt %0d %h/%b, want 1 aabbccdd/1100",
               nm, hdr_cnt, hdr_data, hdr_keep);
    end
    if (bp) begin
      checks++;
      if (stall_cnt == 0 || stall_err != 0) begin
        errors++;
        $display("FAIL bp_stable got stalls %0d changes %0d, want stalls>0 changes 0",
                 stall_cnt, stall_err);
      end
    end
  endtask

  task automatic test_flush();
    clear_mon();
    ready_out = 1'b1;
    send_strip(2'd0);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h11223344, 4'b1111, 1'b1);
    // Now in the flush state; hold it with backpressure for two cycles.
    ready_out = 1'b0;
    idle_cycles(2);
    checks++;
    if ({ready_in, valid_out, last_out, keep_out, data_out} !== {3'b011, 4'b1110, 32'h22334400}) begin
      errors++;
      $display("FAIL flush_hold got rdy %b vld %b last %b %b/%h, want 0 1 1 1110/22334400",
               ready_in, valid_out, last_out, keep_out, data_out);
    end
    ready_out = 1'b1;
    idle_cycles(3);
    checks++;
    if (outq.size() !== 2) begin
      errors++;
      $display("FAIL flush_count got %0d beats, want 2", outq.size());
    end else begin
      checks++;
      if (outq[0] !== {1'b0, 4'b1111, 32'hBBCCDD11}) begin
        errors++;
        $display("FAIL flush_beat0 got %h, want %h", outq[0], {1'b0, 4'b1111, 32'hBBCCDD11});
      end
      checks++;
      if (outq[1] !== {1'b1, 4'b1110, 32'h22334400}) begin
        errors++;
        $display("FAIL flush_beat1 got %h, want %h", outq[1], {1'b1, 4'b1110, 32'h22334400});
      end
    end
  endtask

  task automatic test_header_only();
    clear_mon();
    ready_out = 1'b1;
    send_strip(2'd3);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b1);
    idle_cycles(3);
    checks++;
    if (outq.size() !== 0) begin
      errors++;
      $display("FAIL hdronly_out got %0d beats, want 0", outq.size());
    end
    checks++;
    if (hdr_cnt !== 1 || hdr_data !== 32'hAABBCCDD || hdr_keep !== 4'b1111) begin
      errors++;
      $display("FAIL hdronly_header got cnt %0d %h/%b, want 1 aabbccdd/1111",
               hdr_cnt, hdr_data, hdr_keep);
    end
    checks++;
    if (ready_strip !== 1'b1) begin
      errors++;
      $display("FAIL hdronly_idle ready_strip got %b, want 1", ready_strip);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    ready_out = 1'b1;
    send_strip(2'd1);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    valid_in = 1'b1; data_in = 32'h99887766; keep_in = 4'hF; valid_strip = 1'b1;
    rst = 1'b1;
    #2;
    checks++;
    if ({ready_in, ready_strip, valid_out, last_out, valid_header, data_out, keep_out,
         data_header, keep_header} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got rdy %b rs %b vld %b last %b vh %b d %h k %b, want all 0",
               ready_in, ready_strip, valid_out, last_out, valid_header, data_out, keep_out);
    end
    idle_cycles(1);
    rst = 1'b0; valid_in = 1'b0; valid_strip = 1'b0; keep_in = '0; data_in = '0;
    clear_mon();
    send_strip(2'd0);
    send_beat(32'h01020304, 4'b1000, 1'b1);
    idle_cycles(3);
    checks++;
    if (outq.size() !== 0) begin
      errors++;
      $display("FAIL rstmid_out got %0d beats, want 0", outq.size());
    end
    checks++;
    if (hdr_cnt !== 1 || hdr_data !== 32'h01020304 || hdr_keep !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_header got cnt %0d %h/%b, want 1 01020304/1000",
               hdr_cnt, hdr_data, hdr_keep);
    end
  endtask

`ifdef STRIP_KEEP_CHECK_EN
  task automatic test_keep_check();
    clear_mon();
    ready_out = 1'b1;
    checks++;
    if (err_keep !== 1'b0) begin
      errors++;
      $display("FAIL keep_init got %b, want 0", err_keep);
    end
    send_strip(2'd0);
    send_beat(32'h10203040, 4'b1111, 1'b0);
    send_beat(32'h50607080, 4'b1011, 1'b0);
    checks++;
    if (err_keep !== 1'b1) begin
      errors++;
      $display("FAIL keep_set got %b, want 1", err_keep);
    end
    send_beat(32'h90A0B0C0, 4'b1111, 1'b1);
    idle_cycles(4);
    checks++;
    if (err_keep !== 1'b1) begin
      errors++;
      $display("FAIL keep_sticky got %b, want 1", err_keep);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    idle_cycles(1);
    checks++;
    if (err_keep !== 1'b0) begin
      errors++;
      $display("FAIL keep_clear got %b, want 0", err_keep);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exact_fit(1'b0);
    test_flush();
    test_header_only();
    test_exact_fit(1'b1);
    test_reset_mid();
`ifdef STRIP_KEEP_CHECK_EN
    test_keep_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
- Downstream counterpart of the header-insert stage: strips a per-packet header of 1..DATA_BYTE_WD bytes from the front of each AXI-Stream packet.
- Realigns the remaining payload to the MSB of each beat and reports the removed header bytes on a sideband.
- Byte order: byte 0 of a beat is data[DATA_WD-1 -: 8]; keep bit DATA_BYTE_WD-1 belongs to byte 0.
- Input beats carry full keep, except the last beat, whose keep is MSB-contiguous.

Parameters:
DATA_WD, 32, stream data width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, bytes per beat
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip byte count

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
valid_in  input  1  input stream valid
data_in  input  DATA_WD  input stream data
keep_in  input  DATA_BYTE_WD  input byte enables
last_in  input  1  input end of packet
ready_in  output  1  input stream ready
valid_out  output  1  output stream valid
data_out  output  DATA_WD  realigned payload
keep_out  output  DATA_BYTE_WD  output byte enables, MSB-contiguous
last_out  output  1  output end of packet
ready_out  input  1  downstream ready
valid_strip  input  1  strip command valid
byte_strip_cnt  input  BYTE_CNT_WD  header length minus one (S = cnt+1 bytes)
ready_strip  output  1  strip command ready
valid_header  output  1  one-cycle pulse: header captured
data_header  output  DATA_WD  first input beat of the packet
keep_header  output  DATA_BYTE_WD  top S bits set

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state IDLE; residual register, S, L, and the data_header/keep_header registers are 0.
- While rst is high, all outputs are 0, including ready_strip.
- FSM states: IDLE, FIRST, BODY, FLUSH.
- IDLE:
  - ready_strip=1, ready_in=0, valid_out=0.
  - On valid_strip: latch S=byte_strip_cnt+1 and go to FIRST.
- FIRST:
  - ready_in=1, valid_out=0.
  - On beat accept: res<=data_in; data_header<=data_in; keep_header<=top S bits; valid_header=1 the next cycle.
  - If last_in: L=popcount(keep_in). If L>S, go to FLUSH; otherwise drop the packet (no output) and go to IDLE.
  - Otherwise go to BODY.
- BODY:
  - Combinational pass-through: valid_out=valid_in, ready_in=ready_out.
  - data_out = {low (DATA_BYTE_WD-S) bytes of res, high S bytes of data_in}.
  - On transfer: res<=data_in.
  - If last_in with L<=S: last_out=1, keep_out = top (DATA_BYTE_WD-S+L) bits set, go to IDLE.
  - If last_in with L>S: last_out=0, keep_out all ones, go to FLUSH (latch L).
- FLUSH:
  - ready_in=0, valid_out=1, last_out=1.
  - data_out = res shifted left by S bytes, zero-filled.
  - keep_out = top (L-S) bits set.
  - On ready_out: go to IDLE.
- S=DATA_BYTE_WD: BODY passes data_in unchanged (res contributes no bytes); FLUSH is unreachable.
- Stability: valid_out, data_out, keep_out and last_out are held stable while valid_out=1 and ready_out=0. In BODY this depends on the upstream holding its beat.
- valid_strip arriving outside IDLE is ignored (ready_strip=0).
- Reset mid-packet: immediate return to IDLE; the partial packet is discarded; no last_out is emitted.
- Bytes of data_out with keep_out=0 are driven 0.

Optional Feature:
- Macro: STRIP_KEEP_CHECK_EN.
- When defined, adds port err_keep (output, 1): a sticky flag, cleared only by rst.
- err_keep sets when an accepted beat has:
  - keep_in not all ones with last_in=0, or
  - non-MSB-contiguous keep_in, or
  - keep_in=0.
- The data path is unaffected.
- When undefined: no port, no logic, and keep legality is the upstream's responsibility.

Test Plan:
- Exact-fit last beat:
  - Stimulus: cnt=1 (S=2); beats 0xAABBCCDD/1111, 0x11223344/1111, 0x5566_0000/1100 last.
  - Response: header 0xAABBCCDD keep 1100; out 0xCCDD1122/1111, then 0x33445566/1111 last; no FLUSH.
- Flush beat:
  - Stimulus: cnt=0 (S=1); beats 0xAABBCCDD/1111, 0x11223344/1111 last.
  - Response: out 0xBBCCDD11/1111, then FLUSH 0x22334400/1110 last; ready_in=0 during FLUSH.
- Header-only packet:
  - Stimulus: cnt=3 (S=4); single beat 0xAABBCCDD/1111 last.
  - Response: no valid_out; valid_header pulse with 0xAABBCCDD/1111; back in IDLE with ready_strip=1.
- Backpressure:
  - Stimulus: first case with ready_out toggling 0/1 every cycle.
  - Response: identical output sequence; data is stable while stalled; no beat lost or duplicated.
- Reset mid-packet:
  - Stimulus: assert rst after the 2nd input beat, then send a new cnt=0 packet 0x01020304/1000 last.
  - Response: all outputs 0 during reset; the new packet produces no output (L=1<=S=1); header 0x01020304 keep 1000.
- Keep check:
  - Stimulus (STRIP_KEEP_CHECK_EN defined): mid-packet beat with keep 1011.
  - Response: err_keep=1 from the next cycle until rst.
